// File: rtl/calc_engine_if.sv
// calc_engine_if: operand/mode/result bundle between the stimulus controller
// and calc_engine.
//   a_in, b_in  : operands (WIDTH bits), driven by the controller
//   mode_in     : 8-bit operation select, driven by the controller
//   c_out       : registered result, driven by the engine
//   busy        : operation in progress, driven by the engine
//   done        : one-cycle pulse when c_out is updated, driven by the engine
// Modports: master = controller side, slave = engine side.
interface calc_engine_if #(
    parameter int unsigned WIDTH = 8
);
    timeunit 1ns;
    timeprecision 1ps;

    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [7:0]       mode_in;
    logic [WIDTH-1:0] c_out;
    logic             busy;
    logic             done;

    modport master (
        output a_in, b_in, mode_in,
        input  c_out, busy, done
    );

    modport slave (
        input  a_in, b_in, mode_in,
        output c_out, busy, done
    );
endinterface

// File: rtl/calc_engine.sv
// calc_engine: sequential compute engine. Any change of {a_in, b_in, mode_in}
// relative to the captured snapshot starts a new operation; the latest inputs
// always win. Add/sub/default complete one cycle after capture, shifts take one
// step per bit position, and the optional multiplier takes WIDTH shift-add steps.
// Ports:
//   emu_clk    : clock, all state changes on its rising edge
//   emu_rst_n  : asynchronous active-low reset
//   bus        : calc_engine_if.slave (a_in, b_in, mode_in in; c_out, busy, done out)
// Configuration macro: CALC_ITER_MUL_EN -- when defined, mode 3 is an iterative
// multiply; when undefined, mode 3 returns DEFAULT_RESULT and no multiplier
// state exists.
module calc_engine #(
    parameter int unsigned     WIDTH          = 8,
    parameter logic [WIDTH-1:0] DEFAULT_RESULT = WIDTH'(42)
) (
    input  logic          emu_clk,
    input  logic          emu_rst_n,
    calc_engine_if.slave  bus
);
    timeunit 1ns;
    timeprecision 1ps;

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EXEC = 1'b1;

    localparam logic [7:0] M_ADD  = 8'd0;
    localparam logic [7:0] M_SUB  = 8'd1;
    localparam logic [7:0] M_RSUB = 8'd2;
    localparam logic [7:0] M_MUL  = 8'd3;
    localparam logic [7:0] M_ASR  = 8'd4;
    localparam logic [7:0] M_ASL  = 8'd5;
    localparam logic [7:0] M_BSR  = 8'd6;
    localparam logic [7:0] M_BSL  = 8'd7;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_s_q, a_s_d;
    logic [WIDTH-1:0] b_s_q, b_s_d;
    logic [7:0]       m_s_q, m_s_d;
    logic             snap_vld_q, snap_vld_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;       // shifting operand, or multiplicand
`ifdef CALC_ITER_MUL_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
`endif
    logic [WIDTH-1:0] c_out_q, c_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             capture_c;
    logic [CW-1:0]    load_cnt_c;
    logic [WIDTH-1:0] load_work_c;
    logic [WIDTH-1:0] result_c;

    // Shift step count saturates at WIDTH; that many one-bit steps clears the operand.
    function automatic logic [CW-1:0] clamp_amt(input logic [WIDTH-1:0] amt);
        if (32'(amt) >= WIDTH) begin
            return CW'(WIDTH);
        end
        return CW'(amt);
    endfunction

    // Step count and working operand to load from the live inputs on capture.
    always_comb begin
        load_cnt_c  = '0;
        load_work_c = '0;
        case (bus.mode_in)
            M_ASR, M_ASL: begin
                load_work_c = bus.a_in;
                load_cnt_c  = clamp_amt(bus.b_in);
            end
            M_BSR, M_BSL: begin
                load_work_c = bus.b_in;
                load_cnt_c  = clamp_amt(bus.a_in);
            end
`ifdef CALC_ITER_MUL_EN
            M_MUL: begin
                load_work_c = bus.a_in;
                load_cnt_c  = CW'(WIDTH);
            end
`endif
            default: ;
        endcase
    end

    // Final result from the snapshot and the iteration registers.
    always_comb begin
        result_c = DEFAULT_RESULT;
        case (m_s_q)
            M_ADD:  result_c = a_s_q + b_s_q;
            M_SUB:  result_c = a_s_q - b_s_q;
            M_RSUB: result_c = b_s_q - a_s_q;
`ifdef CALC_ITER_MUL_EN
            M_MUL:  result_c = acc_q;
`endif
            M_ASR, M_ASL, M_BSR, M_BSL: result_c = work_q;
            default: ;
        endcase
    end

    // Next-state, iteration and output logic.
    always_comb begin
        state_d    = state_q;
        a_s_d      = a_s_q;
        b_s_d      = b_s_q;
        m_s_d      = m_s_q;
        snap_vld_d = snap_vld_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
`ifdef CALC_ITER_MUL_EN
        acc_d      = acc_q;
        mplr_d     = mplr_q;
`endif
        c_out_d    = c_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        // A change (or an empty snapshot) restarts from any state and beats completion.
        capture_c = !snap_vld_q ||
                    ({bus.a_in, bus.b_in, bus.mode_in} != {a_s_q, b_s_q, m_s_q});

        if (capture_c) begin
            a_s_d      = bus.a_in;
            b_s_d      = bus.b_in;
            m_s_d      = bus.mode_in;
            snap_vld_d = 1'b1;
            cnt_d      = load_cnt_c;
            work_d     = load_work_c;
`ifdef CALC_ITER_MUL_EN
            acc_d      = '0;
            mplr_d     = bus.b_in;
`endif
            state_d    = S_EXEC;
            busy_d     = 1'b1;
        end else begin
            case (state_q)
                S_EXEC: begin
                    if (cnt_q == '0) begin
                        c_out_d = result_c;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                        case (m_s_q)
                            M_ASR, M_BSR: work_d = work_q >> 1;
                            M_ASL, M_BSL: work_d = work_q << 1;
`ifdef CALC_ITER_MUL_EN
                            M_MUL: begin
                                if (mplr_q[0]) begin
                                    acc_d = acc_q + work_q;
                                end
                                work_d = work_q << 1;
                                mplr_d = mplr_q >> 1;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            state_q    <= S_IDLE;
            a_s_q      <= '0;
            b_s_q      <= '0;
            m_s_q      <= '0;
            snap_vld_q <= 1'b0;
            cnt_q      <= '0;
            work_q     <= '0;
`ifdef CALC_ITER_MUL_EN
            acc_q      <= '0;
            mplr_q     <= '0;
`endif
            c_out_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_s_q      <= a_s_d;
            b_s_q      <= b_s_d;
            m_s_q      <= m_s_d;
            snap_vld_q <= snap_vld_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
`ifdef CALC_ITER_MUL_EN
            acc_q      <= acc_d;
            mplr_q     <= mplr_d;
`endif
            c_out_q    <= c_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.c_out = c_out_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule
